// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the core data bus between the MEM-stage load/store
// unit (port 0) and the CSR/MMU page-table walker (port 1).
// A winner is picked combinationally in IDLE (zero-latency grant) and then
// held until dresp_data_ok. The response is routed only to the owner.
// A hang watchdog, requester protocol checking and saturating per-port
// grant counters are also provided.
module dbus_arbiter #(
    parameter int RR_MODE = 0,     // 0: fixed priority (PTW wins), 1: round-robin
    parameter int TIMEOUT = 1024,  // cycles in BUSY before err, 0 disables
    parameter int CNT_W   = 32     // grant counter width
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    input  logic [1:0][63:0]     req_addr,
    input  logic [1:0][2:0]      req_size,
    input  logic [1:0][7:0]      req_strobe,
    input  logic [1:0][63:0]     req_data,
    output logic [1:0]           rsp_data_ok,
    output logic [63:0]          rsp_data,
    output logic                 dreq_valid,
    output logic [63:0]          dreq_addr,
    output logic [2:0]           dreq_size,
    output logic [7:0]           dreq_strobe,
    output logic [63:0]          dreq_data,
    input  logic                 dresp_data_ok,
    input  logic [63:0]          dresp_data,
    output logic [1:0]           owner,
    output logic                 err,
    output logic [CNT_W-1:0]     gnt_cnt0,
    output logic [CNT_W-1:0]     gnt_cnt1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    // Watchdog compare value: the counter holds (BUSY cycles - 1), so err is
    // raised on the edge that ends the TIMEOUT-th BUSY cycle.
    localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;
    localparam logic        WD_EN   = (TIMEOUT > 0);
    localparam logic        RR_EN   = (RR_MODE != 0);

    // Saturating increment for the grant counters.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Saturating increment for the watchdog counter.
    function automatic logic [31:0] wd_inc(input logic [31:0] v);
        if (v == 32'hFFFF_FFFF) begin
            wd_inc = v;
        end else begin
            wd_inc = v + 32'd1;
        end
    endfunction

    state_t           state_r;
    logic             last_r;       // index of the port served most recently
    logic             err_r;
    logic [31:0]      wd_cnt_r;
    logic [CNT_W-1:0] gnt_cnt0_r;
    logic [CNT_W-1:0] gnt_cnt1_r;

    logic             win_s;        // arbitration winner while IDLE
    logic             active_s;     // a port currently owns the bus
    logic             sel_s;        // index of the owning port
    logic             complete_s;   // owner's transaction finishes this cycle
    logic             violation_s;  // owner dropped req_valid before data_ok
    logic             wd_hit_s;     // watchdog reaches its limit this cycle
    logic [1:0]       owner_s;

    // Arbitration: fixed priority favours the PTW, round-robin alternates on a tie.
    always_comb begin
        win_s = 1'b0;
        if (RR_EN) begin
            case (req_valid)
                2'b01:   win_s = 1'b0;
                2'b10:   win_s = 1'b1;
                2'b11:   win_s = ~last_r;
                default: win_s = 1'b0;
            endcase
        end else begin
            win_s = req_valid[1];
        end
    end

    // Ownership: a fresh grant in IDLE, otherwise the port held by the BUSY state.
    always_comb begin
        active_s = 1'b0;
        sel_s    = 1'b0;
        if (reset) begin
            active_s = 1'b0;
            sel_s    = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    active_s = |req_valid;
                    sel_s    = win_s;
                end
                ST_BUSY0: begin
                    active_s = 1'b1;
                    sel_s    = 1'b0;
                end
                ST_BUSY1: begin
                    active_s = 1'b1;
                    sel_s    = 1'b1;
                end
                default: begin
                    active_s = 1'b0;
                    sel_s    = 1'b0;
                end
            endcase
        end
    end

    // Owner vector and event qualifiers derived from the current ownership.
    always_comb begin
        owner_s     = 2'b00;
        complete_s  = 1'b0;
        violation_s = 1'b0;
        wd_hit_s    = 1'b0;
        if (active_s) begin
            owner_s    = sel_s ? 2'b10 : 2'b01;
            complete_s = dresp_data_ok;
        end else begin
            owner_s    = 2'b00;
            complete_s = 1'b0;
        end
        if (state_r == ST_BUSY0) begin
            violation_s = ~req_valid[0];
            wd_hit_s    = WD_EN && (wd_cnt_r == WD_LAST);
        end else if (state_r == ST_BUSY1) begin
            violation_s = ~req_valid[1];
            wd_hit_s    = WD_EN && (wd_cnt_r == WD_LAST);
        end else begin
            violation_s = 1'b0;
            wd_hit_s    = 1'b0;
        end
    end

    // Downstream request mux: mirrors the owner's live inputs, zero when idle.
    // dreq_valid follows ownership rather than req_valid so that a requester
    // dropping its request cannot withdraw a request already sent downstream.
    always_comb begin
        dreq_valid  = 1'b0;
        dreq_addr   = 64'd0;
        dreq_size   = 3'd0;
        dreq_strobe = 8'd0;
        dreq_data   = 64'd0;
        if (active_s) begin
            dreq_valid  = 1'b1;
            dreq_addr   = req_addr[sel_s];
            dreq_size   = req_size[sel_s];
            dreq_strobe = req_strobe[sel_s];
            dreq_data   = req_data[sel_s];
        end else begin
            dreq_valid  = 1'b0;
        end
    end

    // Arbiter state, watchdog, sticky error and grant counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            last_r     <= 1'b1;
            err_r      <= 1'b0;
            wd_cnt_r   <= 32'd0;
            gnt_cnt0_r <= {CNT_W{1'b0}};
            gnt_cnt1_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (active_s && !dresp_data_ok) begin
                        state_r <= sel_s ? ST_BUSY1 : ST_BUSY0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY0, ST_BUSY1: begin
                    if (dresp_data_ok) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            // Counting completions, not ownership cycles.
            if (complete_s) begin
                last_r <= sel_s;
                if (sel_s) begin
                    gnt_cnt1_r <= sat_inc(gnt_cnt1_r);
                end else begin
                    gnt_cnt0_r <= sat_inc(gnt_cnt0_r);
                end
            end else begin
                last_r <= last_r;
            end

            // Watchdog restarts with every grant issued from IDLE.
            if (state_r == ST_IDLE) begin
                wd_cnt_r <= 32'd0;
            end else begin
                wd_cnt_r <= wd_inc(wd_cnt_r);
            end

            if (wd_hit_s || violation_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign owner       = owner_s;
    assign rsp_data    = dresp_data;
    assign rsp_data_ok = {2{dresp_data_ok}} & owner_s;
    assign err         = err_r;
    assign gnt_cnt0    = gnt_cnt0_r;
    assign gnt_cnt1    = gnt_cnt1_r;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed testbench for dbus_arbiter: one fixed-priority instance and one
// round-robin instance, both with an 8-cycle watchdog, sharing stimulus.
module tb_dbus_arbiter;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid;
    logic [1:0][63:0]  req_addr;
    logic [1:0][2:0]   req_size;
    logic [1:0][7:0]   req_strobe;
    logic [1:0][63:0]  req_data;
    logic              dresp_data_ok;
    logic [63:0]       dresp_data;

    logic [1:0]  f_rsp_data_ok, r_rsp_data_ok;
    logic [63:0] f_rsp_data, r_rsp_data;
    logic        f_dreq_valid, r_dreq_valid;
    logic [63:0] f_dreq_addr, r_dreq_addr;
    logic [2:0]  f_dreq_size, r_dreq_size;
    logic [7:0]  f_dreq_strobe, r_dreq_strobe;
    logic [63:0] f_dreq_data, r_dreq_data;
    logic [1:0]  f_owner, r_owner;
    logic        f_err, r_err;
    logic [31:0] f_gnt_cnt0, f_gnt_cnt1, r_gnt_cnt0, r_gnt_cnt1;

    int pass_cnt;
    int total_cnt;

    dbus_arbiter #(.RR_MODE(0), .TIMEOUT(8), .CNT_W(32)) u_fix (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
        .req_strobe(req_strobe), .req_data(req_data),
        .rsp_data_ok(f_rsp_data_ok), .rsp_data(f_rsp_data),
        .dreq_valid(f_dreq_valid), .dreq_addr(f_dreq_addr), .dreq_size(f_dreq_size),
        .dreq_strobe(f_dreq_strobe), .dreq_data(f_dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .owner(f_owner), .err(f_err), .gnt_cnt0(f_gnt_cnt0), .gnt_cnt1(f_gnt_cnt1)
    );

    dbus_arbiter #(.RR_MODE(1), .TIMEOUT(8), .CNT_W(32)) u_rr (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_size(req_size),
        .req_strobe(req_strobe), .req_data(req_data),
        .rsp_data_ok(r_rsp_data_ok), .rsp_data(r_rsp_data),
        .dreq_valid(r_dreq_valid), .dreq_addr(r_dreq_addr), .dreq_size(r_dreq_size),
        .dreq_strobe(r_dreq_strobe), .dreq_data(r_dreq_data),
        .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
        .owner(r_owner), .err(r_err), .gnt_cnt0(r_gnt_cnt0), .gnt_cnt1(r_gnt_cnt1)
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid     = 2'b00;
        req_addr      = '0;
        req_size      = '0;
        req_strobe    = '0;
        req_data      = '0;
        dresp_data_ok = 1'b0;
        dresp_data    = 64'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total_cnt++; if (f_owner !== 2'b00) $display("FAIL reset_owner: got %b want 00", f_owner); else pass_cnt++;
        total_cnt++; if (f_dreq_valid !== 1'b0) $display("FAIL reset_dreq_valid: got %b want 0", f_dreq_valid); else pass_cnt++;
        total_cnt++; if (f_dreq_addr !== 64'd0) $display("FAIL reset_dreq_addr: got %h want 0", f_dreq_addr); else pass_cnt++;
        total_cnt++; if (f_rsp_data_ok !== 2'b00) $display("FAIL reset_rsp_ok: got %b want 00", f_rsp_data_ok); else pass_cnt++;
        total_cnt++; if (f_err !== 1'b0) $display("FAIL reset_err: got %b want 0", f_err); else pass_cnt++;
        total_cnt++; if (f_gnt_cnt0 !== 32'd0 || f_gnt_cnt1 !== 32'd0)
            $display("FAIL reset_cnts: got %0d/%0d want 0/0", f_gnt_cnt0, f_gnt_cnt1); else pass_cnt++;
    endtask

    task automatic test_single_read();
        int dv_cycles;
        int ok_cnt;
        do_reset();
        dv_cycles = 0;
        ok_cnt = 0;
        req_valid = 2'b01;
        req_addr[0] = 64'h0000_0000_8000_1000;
        req_size[0] = 3'd3;
        req_strobe[0] = 8'h00;
        for (int c = 0; c < 4; c++) begin
            dresp_data_ok = (c == 3);
            dresp_data = (c == 3) ? 64'h0000_0000_0000_DEAD : 64'd0;
            #1;
            if (f_dreq_valid === 1'b1) dv_cycles++;
            if (f_rsp_data_ok === 2'b01) ok_cnt++;
            total_cnt++; if (f_owner !== 2'b01) $display("FAIL single_owner c%0d: got %b want 01", c, f_owner); else pass_cnt++;
            total_cnt++; if (f_dreq_addr !== 64'h0000_0000_8000_1000)
                $display("FAIL single_addr c%0d: got %h want 80001000", c, f_dreq_addr); else pass_cnt++;
            if (c == 3) begin
                total_cnt++; if (f_rsp_data !== 64'h0000_0000_0000_DEAD)
                    $display("FAIL single_rdata: got %h want dead", f_rsp_data); else pass_cnt++;
            end
            tick();
        end
        clear_inputs();
        #1;
        if (f_dreq_valid === 1'b1) dv_cycles++;
        if (f_rsp_data_ok === 2'b01) ok_cnt++;
        total_cnt++; if (dv_cycles != 4) $display("FAIL single_dv_cycles: got %0d want 4", dv_cycles); else pass_cnt++;
        total_cnt++; if (ok_cnt != 1) $display("FAIL single_ok_pulses: got %0d want 1", ok_cnt); else pass_cnt++;
        total_cnt++; if (f_owner !== 2'b00) $display("FAIL single_owner_end: got %b want 00", f_owner); else pass_cnt++;
        total_cnt++; if (f_gnt_cnt0 !== 32'd1 || f_gnt_cnt1 !== 32'd0)
            $display("FAIL single_cnts: got %0d/%0d want 1/0", f_gnt_cnt0, f_gnt_cnt1); else pass_cnt++;
    endtask

    task automatic test_fixed_tie();
        do_reset();
        req_valid = 2'b11;
        req_addr[0] = 64'h0000_0000_8000_0100;
        req_addr[1] = 64'h0000_0000_9000_0100;
        #1;
        total_cnt++; if (f_owner !== 2'b10) $display("FAIL fix_tie_owner: got %b want 10", f_owner); else pass_cnt++;
        total_cnt++; if (f_dreq_addr !== 64'h0000_0000_9000_0100)
            $display("FAIL fix_tie_addr: got %h want 90000100", f_dreq_addr); else pass_cnt++;
        tick();
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_rsp_data_ok !== 2'b10) $display("FAIL fix_tie_ok1: got %b want 10", f_rsp_data_ok); else pass_cnt++;
        tick();
        req_valid = 2'b01;
        dresp_data_ok = 1'b0;
        #1;
        total_cnt++; if (f_owner !== 2'b01) $display("FAIL fix_tie_owner2: got %b want 01", f_owner); else pass_cnt++;
        total_cnt++; if (f_dreq_addr !== 64'h0000_0000_8000_0100)
            $display("FAIL fix_tie_addr2: got %h want 80000100", f_dreq_addr); else pass_cnt++;
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_rsp_data_ok !== 2'b01) $display("FAIL fix_tie_ok0: got %b want 01", f_rsp_data_ok); else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (f_gnt_cnt0 !== 32'd1 || f_gnt_cnt1 !== 32'd1)
            $display("FAIL fix_tie_cnts: got %0d/%0d want 1/1", f_gnt_cnt0, f_gnt_cnt1); else pass_cnt++;
        total_cnt++; if (f_err !== 1'b0) $display("FAIL fix_tie_err: got %b want 0", f_err); else pass_cnt++;
    endtask

    task automatic test_rr_tie();
        logic [1:0] exp;
        do_reset();
        req_valid = 2'b11;
        dresp_data_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            total_cnt++; if (r_owner !== exp) $display("FAIL rr_owner t%0d: got %b want %b", i, r_owner, exp); else pass_cnt++;
            total_cnt++; if (r_rsp_data_ok !== exp) $display("FAIL rr_ok t%0d: got %b want %b", i, r_rsp_data_ok, exp); else pass_cnt++;
            tick();
        end
        clear_inputs();
        #1;
        total_cnt++; if (r_gnt_cnt0 !== 32'd2 || r_gnt_cnt1 !== 32'd2)
            $display("FAIL rr_cnts: got %0d/%0d want 2/2", r_gnt_cnt0, r_gnt_cnt1); else pass_cnt++;
    endtask

    task automatic test_zero_latency();
        do_reset();
        req_valid = 2'b01;
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_rsp_data_ok !== 2'b01) $display("FAIL zl_ok: got %b want 01", f_rsp_data_ok); else pass_cnt++;
        tick();
        req_valid = 2'b10;
        dresp_data_ok = 1'b0;
        #1;
        total_cnt++; if (f_owner !== 2'b10) $display("FAIL zl_next_owner: got %b want 10", f_owner); else pass_cnt++;
        total_cnt++; if (f_gnt_cnt0 !== 32'd1) $display("FAIL zl_cnt0: got %0d want 1", f_gnt_cnt0); else pass_cnt++;
        total_cnt++; if (f_rsp_data_ok !== 2'b00) $display("FAIL zl_no_ok: got %b want 00", f_rsp_data_ok); else pass_cnt++;
        tick();
        #1;
        total_cnt++; if (f_owner !== 2'b10) $display("FAIL zl_busy1_owner: got %b want 10", f_owner); else pass_cnt++;
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_rsp_data_ok !== 2'b10) $display("FAIL zl_ok1: got %b want 10", f_rsp_data_ok); else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (f_gnt_cnt1 !== 32'd1) $display("FAIL zl_cnt1: got %0d want 1", f_gnt_cnt1); else pass_cnt++;
    endtask

    task automatic test_preempt();
        do_reset();
        req_valid = 2'b01;
        req_addr[0] = 64'h0000_0000_8000_2000;
        tick();
        req_valid = 2'b11;
        req_addr[1] = 64'h0000_0000_9000_0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if (f_dreq_addr !== 64'h0000_0000_8000_2000)
                $display("FAIL pre_addr c%0d: got %h want 80002000", c, f_dreq_addr); else pass_cnt++;
            total_cnt++; if (f_owner !== 2'b01) $display("FAIL pre_owner c%0d: got %b want 01", c, f_owner); else pass_cnt++;
            tick();
        end
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_rsp_data_ok !== 2'b01) $display("FAIL pre_ok0: got %b want 01", f_rsp_data_ok); else pass_cnt++;
        tick();
        req_valid = 2'b10;
        dresp_data_ok = 1'b0;
        #1;
        total_cnt++; if (f_owner !== 2'b10) $display("FAIL pre_owner1: got %b want 10", f_owner); else pass_cnt++;
        total_cnt++; if (f_dreq_addr !== 64'h0000_0000_9000_0000)
            $display("FAIL pre_addr1: got %h want 90000000", f_dreq_addr); else pass_cnt++;
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_rsp_data_ok !== 2'b10) $display("FAIL pre_ok1: got %b want 10", f_rsp_data_ok); else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (f_err !== 1'b0) $display("FAIL pre_err: got %b want 0", f_err); else pass_cnt++;
    endtask

    task automatic test_timeout();
        do_reset();
        req_valid = 2'b01;
        for (int n = 1; n <= 8; n++) begin
            tick();
        end
        #1;
        total_cnt++; if (f_err !== 1'b0) $display("FAIL wd_early: got %b want 0", f_err); else pass_cnt++;
        tick();
        total_cnt++; if (f_err !== 1'b1) $display("FAIL wd_err: got %b want 1", f_err); else pass_cnt++;
        total_cnt++; if (f_dreq_valid !== 1'b1) $display("FAIL wd_dv: got %b want 1", f_dreq_valid); else pass_cnt++;
        total_cnt++; if (f_owner !== 2'b01) $display("FAIL wd_owner: got %b want 01", f_owner); else pass_cnt++;
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_rsp_data_ok !== 2'b01) $display("FAIL wd_ok: got %b want 01", f_rsp_data_ok); else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (f_err !== 1'b1) $display("FAIL wd_sticky: got %b want 1", f_err); else pass_cnt++;
    endtask

    task automatic test_violation();
        do_reset();
        req_valid = 2'b01;
        req_addr[0] = 64'h0000_0000_8000_3000;
        tick();
        req_valid = 2'b00;
        #1;
        total_cnt++; if (f_dreq_valid !== 1'b1) $display("FAIL viol_dv: got %b want 1", f_dreq_valid); else pass_cnt++;
        total_cnt++; if (f_err !== 1'b0) $display("FAIL viol_err_early: got %b want 0", f_err); else pass_cnt++;
        tick();
        total_cnt++; if (f_err !== 1'b1) $display("FAIL viol_err: got %b want 1", f_err); else pass_cnt++;
        total_cnt++; if (f_dreq_addr !== 64'h0000_0000_8000_3000)
            $display("FAIL viol_addr: got %h want 80003000", f_dreq_addr); else pass_cnt++;
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_rsp_data_ok !== 2'b01) $display("FAIL viol_ok: got %b want 01", f_rsp_data_ok); else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++; if (f_owner !== 2'b00) $display("FAIL viol_owner_end: got %b want 00", f_owner); else pass_cnt++;
        total_cnt++; if (f_gnt_cnt0 !== 32'd1) $display("FAIL viol_cnt0: got %0d want 1", f_gnt_cnt0); else pass_cnt++;
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        req_valid = 2'b01;
        tick();
        tick();
        total_cnt++; if (f_owner !== 2'b01) $display("FAIL rst_mid_owner_busy: got %b want 01", f_owner); else pass_cnt++;
        req_valid = 2'b00;
        tick();
        total_cnt++; if (f_err !== 1'b1) $display("FAIL rst_mid_err_set: got %b want 1", f_err); else pass_cnt++;
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
        dresp_data_ok = 1'b1;
        #1;
        total_cnt++; if (f_owner !== 2'b00) $display("FAIL rst_mid_owner: got %b want 00", f_owner); else pass_cnt++;
        total_cnt++; if (f_dreq_valid !== 1'b0) $display("FAIL rst_mid_dv: got %b want 0", f_dreq_valid); else pass_cnt++;
        total_cnt++; if (f_err !== 1'b0) $display("FAIL rst_mid_err: got %b want 0", f_err); else pass_cnt++;
        total_cnt++; if (f_rsp_data_ok !== 2'b00) $display("FAIL rst_mid_drop_ok: got %b want 00", f_rsp_data_ok); else pass_cnt++;
        tick();
        clear_inputs();
    endtask

    // Test sequence.
    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_single_read();
        test_fixed_tie();
        test_rr_tie();
        test_zero_latency();
        test_preempt();
        test_timeout();
        test_violation();
        test_reset_mid_busy();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
